// File: rtl/round_sequencer.sv
// Game-round controller for the bongo rhythm game: sequences the note stream,
// scrolls the target sprite, judges key presses and keeps score/miss/combo counts.
module round_sequencer #(
    parameter int DELAY_INIT = 5000000,
    parameter int DELAY_STEP = 500000,
    parameter int DELAY_MIN  = 1000000,
    parameter int X_START    = 160,
    parameter int X_WRAP     = 48,
    parameter int EPS        = 10,
    parameter int NUM_NOTES  = 120,
    parameter int MAX_MISSES = 8
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] key_n,
    input  logic [1:0] note_code,
    output logic [8:0] xoffset,
    output logic       load_stream,
    output logic       shift_stream,
    output logic       hit,
    output logic       miss,
    output logic [7:0] score,
    output logic [3:0] misses,
    output logic [7:0] combo,
    output logic       game_over,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        PLAY    = 3'd2,
        ADVANCE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [23:0] D_INIT   = 24'(DELAY_INIT);
    localparam logic [23:0] D_STEP   = 24'(DELAY_STEP);
    localparam logic [23:0] D_MIN    = 24'(DELAY_MIN);
    localparam logic [24:0] D_FLOOR  = 25'(DELAY_MIN) + 25'(DELAY_STEP);
    localparam logic [8:0]  X_ST     = 9'(X_START);
    localparam logic [8:0]  X_WR     = 9'(X_WRAP);
    localparam logic [8:0]  X_EPS    = 9'(EPS);
    localparam logic [7:0]  LAST_IDX = 8'(NUM_NOTES - 1);
    localparam logic [3:0]  MISS_LIM = 4'(MAX_MISSES);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Note code to the single active-high press bit it demands (KEY0 is code 11).
    function automatic logic [2:0] key_for(input logic [1:0] code);
        case (code)
            2'b01:   return 3'b010;
            2'b10:   return 3'b100;
            2'b11:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Speed-up by one step, clamped at the floor without ever underflowing.
    function automatic logic [23:0] next_delay(input logic [23:0] cur);
        return ({1'b0, cur} >= D_FLOOR) ? cur - D_STEP : D_MIN;
    endfunction

    state_t      st;
    logic [23:0] cur_delay;
    logic [23:0] delay_cnt;
    logic [7:0]  note_idx;
    logic        judged;
    logic [2:0]  key_prev;

    logic [2:0]  press;
    logic        judge_en;
    logic        good_press;
    logic        adv_miss;
    logic [3:0]  misses_adv;
    logic [23:0] delay_nxt;

    assign press      = key_prev & ~key_n;
    assign judge_en   = (st == PLAY) && (xoffset < X_EPS) && (note_code != 2'b00)
                        && !judged && (press != 3'b000);
    assign good_press = (press == key_for(note_code));
    assign adv_miss   = !judged && (note_code != 2'b00);
    assign misses_adv = adv_miss ? sat_inc4(misses) : misses;
    assign delay_nxt  = next_delay(cur_delay);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            st        <= IDLE;
            xoffset   <= X_ST;
            score     <= 8'd0;
            misses    <= 4'd0;
            combo     <= 8'd0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            cur_delay <= D_INIT;
            delay_cnt <= D_INIT;
            judged    <= 1'b0;
            note_idx  <= 8'd0;
            key_prev  <= 3'b111;
        end else begin
            key_prev <= key_n;
            hit      <= 1'b0;
            miss     <= 1'b0;
            case (st)
                IDLE: begin
                    if (start) st <= LOAD;
                end
                LOAD: begin
                    score     <= 8'd0;
                    misses    <= 4'd0;
                    combo     <= 8'd0;
                    note_idx  <= 8'd0;
                    judged    <= 1'b0;
                    cur_delay <= D_INIT;
                    delay_cnt <= D_INIT;
                    xoffset   <= X_ST;
                    st        <= PLAY;
                end
                PLAY: begin
                    // Judgement sees the xoffset from before this cycle's scroll step.
                    if (judge_en) begin
                        judged <= 1'b1;
                        if (good_press) begin
                            hit   <= 1'b1;
                            score <= sat_inc8(score);
                            combo <= sat_inc8(combo);
                        end else begin
                            miss   <= 1'b1;
                            misses <= sat_inc4(misses);
                            combo  <= 8'd0;
                        end
                    end
                    if (delay_cnt == 24'd0) begin
                        delay_cnt <= cur_delay;
                        if (xoffset == 9'd0) st <= ADVANCE;
                        else                 xoffset <= xoffset - 9'd1;
                    end else begin
                        delay_cnt <= delay_cnt - 24'd1;
                    end
                end
                ADVANCE: begin
                    if (adv_miss) begin
                        miss  <= 1'b1;
                        combo <= 8'd0;
                    end
                    misses    <= misses_adv;
                    note_idx  <= note_idx + 8'd1;
                    xoffset   <= X_WR;
                    judged    <= 1'b0;
                    cur_delay <= delay_nxt;
                    delay_cnt <= delay_nxt;
                    st <= ((note_idx == LAST_IDX) || (misses_adv >= MISS_LIM)) ? DONE : PLAY;
                end
                DONE: begin
                    if (start) st <= LOAD;
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign state        = st;
    assign load_stream  = (st == LOAD);
    assign shift_stream = (st == ADVANCE);
    assign game_over    = (st == DONE);

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
Game-round controller for the bongo rhythm game. It sequences the note-stream datapath: it loads the stream, scrolls the target sprite right-to-left at a rate that speeds up, and advances the stream one note per pass. It also judges key presses against the head note inside the hit window and keeps score, miss and combo counts. It sits between the pushbutton inputs, the note-stream register and the animation/score-display modules.

Parameters:
DELAY_INIT, 5000000, initial CLOCK_50 cycles per 1-pixel scroll step
DELAY_STEP, 500000, decrease of step period after each note pass
DELAY_MIN, 1000000, floor of step period (clamped, never wraps)
X_START, 160, sprite x on load
X_WRAP, 48, sprite x after each note pass
EPS, 10, hit window: judged while xoffset < EPS
NUM_NOTES, 120, notes per round
MAX_MISSES, 8, miss count that ends the round

Ports:
CLOCK_50  in   1   system clock
reset     in   1   asynchronous, active-high reset
start     in   1   level; begins a round from IDLE or DONE
key_n     in   3   active-low pushbuttons KEY[2:0], already synchronised
note_code in   2   head note of stream: 00 rest, 01 KEY1, 10 KEY2, 11 KEY0
xoffset   out  9   sprite x position
load_stream  out 1 1-cycle pulse: stream register loads the song
shift_stream out 1 1-cycle pulse: stream shifts by one note (2 bits)
hit       out  1   1-cycle pulse on a correct press
miss      out  1   1-cycle pulse on a wrong press or an unplayed note
score     out  8   hits this round, saturates at 255
misses    out  4   misses this round, saturates at 15
combo     out  8   consecutive hits, saturates at 255
game_over out  1   high in DONE
state     out  3   IDLE=0, LOAD=1, PLAY=2, ADVANCE=3, DONE=4

Behaviour:
- Reset (async, any state): state=IDLE; xoffset=X_START; all counts and pulses 0; cur_delay=DELAY_INIT; judged=0; note_idx=0; key history=all released.
- Press event: press[i]=1 for one cycle when key_n[i] goes 1->0, from a registered previous sample. Holding a key gives one event only.
- load_stream=1 exactly while state==LOAD; shift_stream=1 exactly while state==ADVANCE (Moore).
- IDLE: start=1 -> LOAD.
- LOAD (1 cycle): score, misses and combo cleared to 0; note_idx=0; judged=0; cur_delay=delay_cnt=DELAY_INIT; xoffset=X_START -> PLAY.
- PLAY:
  - delay_cnt decrements each cycle.
  - When delay_cnt==0: if xoffset==0 -> ADVANCE; else xoffset-1. In both cases delay_cnt=cur_delay.
  - Judgement uses pre-update xoffset. It applies only when xoffset<EPS, note_code!=00 and judged==0.
    - Press set equals exactly the required key: next cycle hit=1, score+1, combo+1, judged=1.
    - Any other non-empty press set: next cycle miss=1, misses+1, combo=0, judged=1.
  - Presses outside the window, on rests, or after judgement are ignored.
  - start is ignored.
- ADVANCE (1 cycle):
  - If judged==0 and note_code!=00: miss=1 next cycle, misses+1, combo=0.
  - note_idx+1; xoffset=X_WRAP; judged=0; cur_delay=max(cur_delay-DELAY_STEP, DELAY_MIN); delay_cnt=new cur_delay.
  - Next state is DONE if note_idx==NUM_NOTES-1 or the updated misses>=MAX_MISSES; otherwise PLAY.
  - Presses in ADVANCE are ignored.
- DONE: game_over=1; score, misses, combo and xoffset hold. start=1 -> LOAD.
- Arithmetic: delay counters 24-bit, note_idx 8-bit. The cur_delay subtraction is computed with a compare, never an underflow.

Test Plan:
Parameters for all scenarios: DELAY_INIT=4, DELAY_STEP=1, DELAY_MIN=2, X_START=12, X_WRAP=6, EPS=3, NUM_NOTES=3, MAX_MISSES=2.
1. Reset then a 1-cycle start pulse -> state 0->1->2; load_stream high exactly 1 cycle; xoffset=12; score, misses and combo = 0; xoffset steps 12->11 after 5 cycles in PLAY.
2. note_code=01; press KEY1 (key_n 111->101) when xoffset=2 -> one hit pulse; score=1, combo=1. A second press at xoffset=1 gives no pulse.
3. note_code=10; press KEY0 at xoffset=1 -> miss=1, misses=1, combo=0. Reaching xoffset 0 then ADVANCE gives no second miss.
4. note_code=11; no press -> in ADVANCE: shift_stream pulse, miss pulse, xoffset=6; cur_delay 4->3, then 2, then stays at 2.
5. Two unplayed non-rest notes -> misses=2, state=DONE, game_over=1; start -> LOAD clears the counts.
6. Assert reset mid-PLAY between clock edges -> outputs return to reset values immediately; state=IDLE, xoffset=12.
